fx_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the shared fx bus.
- Port 0 is the UART fx_master. Port 1 is a local requester, for example a housekeeping or config sequencer.
- Each side issues single-byte read/write transactions through a req/ack handshake. The arbiter grants round-robin, drives exactly one fx_wr or fx_rd strobe per transaction, waits the fixed read latency, and returns read data with the ack.

---
 rtl/fx_arbiter_if.sv | 48 ++++
 rtl/fx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fx_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fx_arbiter_if.sv
// Signal bundle between the two fx requesters, the arbiter and the shared fx bus.
// The slave modport is the arbiter's view; master is the requester/bus-model side.
interface fx_arbiter_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 8
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic              fx_wr;
  logic [ADDR_W-1:0] fx_waddr;
  logic [DATA_W-1:0] fx_data;
  logic              fx_rd;
  logic [ADDR_W-1:0] fx_raddr;
  logic [DATA_W-1:0] fx_q;

  logic              busy;
  logic              owner;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  fx_q,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
    output busy, owner
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output fx_q,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
    input  busy, owner
  );
endinterface

// File: rtl/fx_arbiter.sv
// Round-robin arbiter/sequencer giving the UART master (port 0) and a local
// requester (port 1) single-byte read/write access to the shared fx bus.
module fx_arbiter #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input logic        clk_sys,
  input logic        rst,
  fx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic              owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;

  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Every output is a register; this block only computes their next values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    waddr_d  = waddr_q;
    raddr_d  = raddr_q;
    data_d   = data_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;

    // Contention goes to the port that did not win last time.
    pick = ~owner_q;
    if (bus.m0_req && !bus.m1_req) begin
      pick = 1'b0;
    end else if (!bus.m0_req && bus.m1_req) begin
      pick = 1'b1;
    end
    sel_we    = pick ? bus.m1_we    : bus.m0_we;
    sel_addr  = pick ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = pick ? bus.m1_wdata : bus.m0_wdata;

    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          gnt_d   = pick;
          owner_d = pick;
          if (sel_we) begin
            wr_d    = 1'b1;
            waddr_d = sel_addr;
            data_d  = sel_wdata;
          end else begin
            rd_d    = 1'b1;
            raddr_d = sel_addr;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // The registered strobe doubles as the latched direction.
        if (wr_q) begin
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = DONE;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          if (gnt_q) begin
            rdata1_d = bus.fx_q;
          end else begin
            rdata0_d = bus.fx_q;
          end
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      gnt_q    <= 1'b0;
      owner_q  <= 1'b1;
      busy_q   <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      data_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      data_q   <= data_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
    end
  end

  assign bus.fx_wr    = wr_q;
  assign bus.fx_rd    = rd_q;
  assign bus.fx_waddr = waddr_q;
  assign bus.fx_raddr = raddr_q;
  assign bus.fx_data  = data_q;
  assign bus.m0_ack   = ack0_q;
  assign bus.m1_ack   = ack1_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;
  assign bus.busy     = busy_q;
  assign bus.owner    = owner_q;

endmodule

// File: tb/tb_fx_arbiter.sv
// Directed scoreboard bench for fx_arbiter: expected strobes and acks are queued
// when requests are driven and checked by a monitor when the DUT produces them.
module tb_fx_arbiter;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;

  typedef struct {
    bit          port;
    bit          we;
    logic [21:0] addr;
    logic [7:0]  data;
    int          scyc;
    int          acyc;
  } txn_t;

  logic       clk_sys = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         rd_due = -1;
  logic [7:0] rd_val = 8'h00;
  logic [7:0] exp_rdata [2];
  txn_t       strb_q [$];
  txn_t       ack_q [$];

  fx_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fx_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk_sys(clk_sys),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // fx bus slave model: read data is valid only in strobe cycle + RD_LAT.
  always @(posedge clk_sys) begin
    #1;
    bus.fx_q = (cyc == rd_due) ? rd_val : 8'hEE;
  end

  function automatic logic [7:0] memData(input logic [21:0] a);
    return a[7:0] ^ 8'hA3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void pushTxn(input bit port, input bit we, input logic [21:0] addr,
                                  input logic [7:0] wdata, input int scyc, input bit with_ack);
    txn_t t;
    t.port = port;
    t.we   = we;
    t.addr = addr;
    t.data = wdata;
    t.scyc = scyc;
    t.acyc = we ? scyc + 1 : scyc + 1 + RD_LAT;
    strb_q.push_back(t);
    if (with_ack) begin
      if (!we) exp_rdata[port] = memData(addr);
      t.data = exp_rdata[port];
      ack_q.push_back(t);
    end
  endfunction

  always @(negedge clk_sys) begin : monitor
    txn_t e;
    if (rst === 1'b0) begin
      if (bus.fx_wr === 1'b1 || bus.fx_rd === 1'b1) begin
        checkOutput("strobe_excl", 32'(bus.fx_wr & bus.fx_rd), 0);
        checkOutput("strobe_expected", 32'(strb_q.size() != 0), 1);
        if (bus.fx_rd === 1'b1) begin
          rd_due = cyc + RD_LAT;
          rd_val = memData(bus.fx_raddr);
        end
        if (strb_q.size() != 0) begin
          e = strb_q.pop_front();
          checkOutput("strobe_cycle", cyc, e.scyc);
          checkOutput("fx_wr", 32'(bus.fx_wr), 32'(e.we));
          checkOutput("fx_rd", 32'(bus.fx_rd), 32'(!e.we));
          checkOutput("busy_in_issue", 32'(bus.busy), 1);
          if (e.we) begin
            checkOutput("fx_waddr", 32'(bus.fx_waddr), 32'(e.addr));
            checkOutput("fx_data", 32'(bus.fx_data), 32'(e.data));
          end else begin
            checkOutput("fx_raddr", 32'(bus.fx_raddr), 32'(e.addr));
          end
        end
      end
      if (bus.m0_ack === 1'b1 || bus.m1_ack === 1'b1) begin
        checkOutput("ack_excl", 32'(bus.m0_ack & bus.m1_ack), 0);
        checkOutput("ack_expected", 32'(ack_q.size() != 0), 1);
        if (ack_q.size() != 0) begin
          e = ack_q.pop_front();
          checkOutput("ack_port", 32'(bus.m1_ack), 32'(e.port));
          checkOutput("ack_cycle", cyc, e.acyc);
          checkOutput("rdata", 32'(e.port ? bus.m1_rdata : bus.m0_rdata), 32'(e.data));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic applyStimulus(input bit port, input bit we, input logic [21:0] addr, input logic [7:0] wdata);
    if (port) begin
      bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end else begin
      bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end
  endtask

  task automatic releaseReq(input bit port);
    if (port) bus.m1_req = 1'b0;
    else      bus.m0_req = 1'b0;
  endtask

  task automatic waitAck(input bit port);
    bit    got;
    string tag;
    got = 1'b0;
    tag = port ? "ack_wait_m1" : "ack_wait_m0";
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_sys);
      got = port ? (bus.m1_ack === 1'b1) : (bus.m0_ack === 1'b1);
    end
    checkOutput(tag, 32'(got), 1);
  endtask

  task automatic waitAnyAck(output bit port);
    bit got;
    got  = 1'b0;
    port = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_sys);
      got  = (bus.m0_ack === 1'b1) || (bus.m1_ack === 1'b1);
      port = (bus.m1_ack === 1'b1);
    end
    checkOutput("ack_wait_any", 32'(got), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    int n0;
    int n1;
    bit p;
    logic [21:0] caddr;
    logic [7:0]  cdata;

    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;

    // Reset state and quiet idle period
    repeat (3) @(posedge clk_sys);
    #1 rst = 1'b0;
    @(negedge clk_sys);
    checkOutput("rst_fx_wr", 32'(bus.fx_wr), 0);
    checkOutput("rst_fx_rd", 32'(bus.fx_rd), 0);
    checkOutput("rst_m0_ack", 32'(bus.m0_ack), 0);
    checkOutput("rst_m1_ack", 32'(bus.m1_ack), 0);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_owner", 32'(bus.owner), 1);
    checkOutput("rst_fx_waddr", 32'(bus.fx_waddr), 0);
    checkOutput("rst_fx_raddr", 32'(bus.fx_raddr), 0);
    checkOutput("rst_fx_data", 32'(bus.fx_data), 0);
    checkOutput("rst_m0_rdata", 32'(bus.m0_rdata), 0);
    checkOutput("rst_m1_rdata", 32'(bus.m1_rdata), 0);
    repeat (20) @(negedge clk_sys);
    checkOutput("idle_busy", 32'(bus.busy), 0);

    // Single write from port 0
    step();
    c0 = cyc;
    applyStimulus(1'b0, 1'b1, 22'h012345, 8'hA5);
    pushTxn(1'b0, 1'b1, 22'h012345, 8'hA5, c0 + 1, 1'b1);
    waitAck(1'b0);
    step();
    releaseReq(1'b0);
    @(negedge clk_sys);
    checkOutput("owner_after_m0", 32'(bus.owner), 0);

    // Single read from port 1 at the top address
    step();
    c0 = cyc;
    applyStimulus(1'b1, 1'b0, 22'h3FFFFF, 8'h00);
    pushTxn(1'b1, 1'b0, 22'h3FFFFF, 8'h00, c0 + 1, 1'b1);
    waitAck(1'b1);
    step();
    releaseReq(1'b1);
    @(negedge clk_sys);
    checkOutput("owner_after_m1", 32'(bus.owner), 1);

    // Contention: both ports hold write requests for four transactions each
    step();
    c0 = cyc;
    applyStimulus(1'b0, 1'b1, 22'h000100, 8'h11);
    applyStimulus(1'b1, 1'b1, 22'h000200, 8'h22);
    for (int k = 0; k < 8; k++) begin
      caddr = (k % 2 == 1) ? 22'h000200 : 22'h000100;
      cdata = (k % 2 == 1) ? 8'h22 : 8'h11;
      pushTxn(k % 2 == 1, 1'b1, caddr, cdata, c0 + 1 + 3 * k, 1'b1);
    end
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 8; k++) begin
      waitAnyAck(p);
      step();
      if (p) n1++;
      else   n0++;
      if (n0 >= 4) releaseReq(1'b0);
      if (n1 >= 4) releaseReq(1'b1);
    end
    releaseReq(1'b0);
    releaseReq(1'b1);
    repeat (4) @(negedge clk_sys);
    checkOutput("m0_ack_count", n0, 4);
    checkOutput("m1_ack_count", n1, 4);

    // Back-to-back writes with inputs changed during ISSUE
    step();
    c0 = cyc;
    applyStimulus(1'b0, 1'b1, 22'h0ABCDE, 8'h5A);
    pushTxn(1'b0, 1'b1, 22'h0ABCDE, 8'h5A, c0 + 1, 1'b1);
    pushTxn(1'b0, 1'b1, 22'h155555, 8'hC3, c0 + 4, 1'b1);
    step();
    bus.m0_addr  = 22'h155555;
    bus.m0_wdata = 8'hC3;
    waitAck(1'b0);
    waitAck(1'b0);
    step();
    releaseReq(1'b0);

    // Reset during WAIT of a read aborts it
    step();
    c0 = cyc;
    applyStimulus(1'b1, 1'b0, 22'h000042, 8'h00);
    pushTxn(1'b1, 1'b0, 22'h000042, 8'h00, c0 + 1, 1'b0);
    step();
    step();
    rst = 1'b1;
    releaseReq(1'b1);
    step();
    rst = 1'b0;
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    @(negedge clk_sys);
    checkOutput("abort_busy", 32'(bus.busy), 0);
    checkOutput("abort_owner", 32'(bus.owner), 1);
    checkOutput("abort_fx_raddr", 32'(bus.fx_raddr), 0);
    checkOutput("abort_m1_rdata", 32'(bus.m1_rdata), 0);
    repeat (6) @(negedge clk_sys);

    // Simultaneous requests after reset: port 0 read wins, then port 1 write
    step();
    c0 = cyc;
    applyStimulus(1'b0, 1'b0, 22'h1234A0, 8'h00);
    applyStimulus(1'b1, 1'b1, 22'h2AAAAA, 8'h7E);
    pushTxn(1'b0, 1'b0, 22'h1234A0, 8'h00, c0 + 1, 1'b1);
    pushTxn(1'b1, 1'b1, 22'h2AAAAA, 8'h7E, c0 + 3 + RD_LAT + 1, 1'b1);
    waitAck(1'b0);
    step();
    releaseReq(1'b0);
    waitAck(1'b1);
    step();
    releaseReq(1'b1);

    repeat (6) @(negedge clk_sys);
    checkOutput("strobe_queue_drained", strb_q.size(), 0);
    checkOutput("ack_queue_drained", ack_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
